// File: rtl/sw_match_latch.sv
// rtl/sw_match_latch.sv - switch-code latch with debounced button, fail counter and timed lockout
// Optional macro SW_MATCH_BLINK_EN: LEDs follow lockout counter bit 3 while in LOCKOUT.
module sw_match_latch #(
  parameter int            N           = 5,
  parameter logic [N-1:0]  PATTERN     = {N{1'b1}},
  parameter int            DEB_CYCLES  = 16,
  parameter int            MAX_FAIL    = 3,
  parameter int            LOCK_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N-1:0]                    sw,
  input  logic                            btn,
  output logic [N-1:0]                    led,
  output logic                            locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int DW = $clog2(DEB_CYCLES);
  // Lockout counter is at least 4 bits so bit 3 exists for the blink pattern.
  localparam int LW = ($clog2(LOCK_CYCLES) < 4) ? 4 : $clog2(LOCK_CYCLES);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  logic [N-1:0]  sw_m_q, sw_s_q;
  logic          btn_m_q, btn_s_q;
  logic          btn_db_q, btn_db_d;
  logic          btn_db_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  state_t        state_q, state_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [N-1:0]  led_q, led_d;
  logic          locked_q, locked_d;
  logic          press;
  logic          match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_m_q  <= '0;
      sw_s_q  <= '0;
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sw_m_q  <= sw;
      sw_s_q  <= sw_m_q;
      btn_m_q <= btn;
      btn_s_q <= btn_m_q;
    end
  end

  // A new level is accepted only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_cnt_d = '0;
    btn_db_d  = btn_db_q;
    if (btn_s_q != btn_db_q) begin
      if (deb_cnt_q == DEB_MAX) begin
        btn_db_d = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q     <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
    end else begin
      deb_cnt_q     <= deb_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
    end
  end

  assign press = btn_db_q & ~btn_db_prev_q;
  assign match = (sw_s_q == PATTERN);

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          if (match) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else if (fail_q != FAIL_MAX) begin
            fail_d = fail_q + FW'(1);
            if (fail_d == FAIL_MAX) begin
              state_d    = ST_LOCKOUT;
              lock_cnt_d = '0;
            end
          end
        end
      end
      ST_OPEN: begin
        // Switch change and relock press together still make one exit.
        if (!match || press) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_MAX) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    led_d    = '0;
    locked_d = (state_d == ST_LOCKOUT);
    if (state_d == ST_OPEN) begin
      led_d = '1;
    end
`ifdef SW_MATCH_BLINK_EN
    else if (state_d == ST_LOCKOUT) begin
      led_d = {N{lock_cnt_d[3]}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      led_q      <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
      led_q      <= led_d;
      locked_q   <= locked_d;
    end
  end

  assign led      = led_q;
  assign locked   = locked_q;
  assign fail_cnt = fail_q;

endmodule
